aemb_wb_arbiter: RTL and testbench

- Two-master to one-slave Wishbone arbiter for the AEMB2 core.
- Shares one single-port memory/peripheral bus between the instruction fetch bus (IWB, read-only) and the data bus (DWB).
- Sits between aeMB2 and the shared RAM/ROM slave. Uses registered round-robin grant, DWB cycle lock, and a per-transfer watchdog that terminates dead transfers.

---
 rtl/aemb_wb_pkg.sv | 19 +
 rtl/aemb_wb_wdog.sv | 34 +++
 rtl/aemb_wb_arbiter.sv | 161 ++++++++++++++++
 tb/tb_aemb_wb_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aemb_wb_pkg.sv
// Shared definitions for the AEMB2 Wishbone arbiter: state encoding,
// bus width and master identifiers.
package aemb_wb_pkg;

    localparam int         DW      = 32;     // bus data width
    localparam logic [3:0] SEL_ALL = 4'hF;   // full-word byte selects

    // Arbiter grant states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IGNT = 2'd1,
        ST_DGNT = 2'd2
    } arb_state_e;

    // Master identifiers held in the round-robin 'last served' flag
    localparam logic M_I = 1'b0;
    localparam logic M_D = 1'b1;

endpackage

// File: rtl/aemb_wb_wdog.sv
// Per-transfer watchdog: counts stalled grant cycles and fires an expire
// strobe when the count reaches TMO. TMO of 0 disables the watchdog.
module aemb_wb_wdog #(
    parameter int TMO = 255,
    parameter int TW  = 8
) (
    input  logic sys_clk_i,
    input  logic sys_rst_ni,
    input  logic clr,       // restart the count (state change or ack)
    input  logic en,        // granted strobe high, no slave ack
    output logic expire
);

    localparam logic [TW-1:0] LIMIT = TW'(TMO);

    logic [TW-1:0] cnt;

    // Stall counter: clear has priority over counting
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples pre-edge values regardless of block ordering.
        if (!sys_rst_ni) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TW'(1);
        end
    end

    // Expire only while still stalled, so a same-cycle slave ack wins
    assign expire = (TMO != 0) && en && (cnt == LIMIT);

endmodule

// File: rtl/aemb_wb_arbiter.sv
// Two-master (IWB read-only, DWB read/write) to one-slave Wishbone arbiter
// for the AEMB2 core. Registered round-robin grant, DWB cycle lock and a
// watchdog that terminates transfers the slave never acknowledges.
module aemb_wb_arbiter
    import aemb_wb_pkg::*;
#(
    parameter int AW  = 16,
    parameter int TMO = 255,
    parameter int TW  = 8
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_ni,
    // instruction fetch master
    input  logic [AW-1:2] iwb_adr_i,
    input  logic          iwb_stb_i,
    output logic          iwb_ack_o,
    output logic [DW-1:0] iwb_dat_o,
    // data master
    input  logic [AW-1:2] dwb_adr_i,
    input  logic [DW-1:0] dwb_dat_i,
    input  logic [3:0]    dwb_sel_i,
    input  logic          dwb_wre_i,
    input  logic          dwb_stb_i,
    input  logic          dwb_cyc_i,
    output logic          dwb_ack_o,
    output logic [DW-1:0] dwb_dat_o,
    // shared slave
    output logic [AW-1:2] xwb_adr_o,
    output logic [DW-1:0] xwb_dat_o,
    output logic [3:0]    xwb_sel_o,
    output logic          xwb_wre_o,
    output logic          xwb_stb_o,
    output logic          xwb_cyc_o,
    input  logic          xwb_ack_i,
    input  logic [DW-1:0] xwb_dat_i,
    // watchdog termination pulse
    output logic          arb_tmo_o
);

    arb_state_e state, state_nxt;
    logic       last,  last_nxt;

    logic gnt_stb;   // strobe of the currently granted master
    logic slv_ack;   // slave ack that actually completes a transfer
    logic tmo;       // watchdog termination this cycle
    logic wd_clr;

    // Qualified strobe/ack: acks outside a grant or with stb low are ignored
    always_comb begin
        gnt_stb = 1'b0;
        if (state == ST_IGNT) gnt_stb = iwb_stb_i;
        if (state == ST_DGNT) gnt_stb = dwb_stb_i;
        slv_ack = gnt_stb & xwb_ack_i;
    end

    assign wd_clr = (state_nxt != state) | slv_ack;

    aemb_wb_wdog #(
        .TMO (TMO),
        .TW  (TW)
    ) u_wdog (
        .sys_clk_i  (sys_clk_i),
        .sys_rst_ni (sys_rst_ni),
        .clr        (wd_clr),
        .en         (gnt_stb & ~xwb_ack_i),
        .expire     (tmo)
    );

    // Grant state and round-robin history register
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            state <= ST_IDLE;
            last  <= M_I;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // Next-state: round-robin on ties, direct hand-over after ack, DWB lock
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so
        // no path through the case leaves it unassigned and infers a latch.
        state_nxt = state;
        last_nxt  = last;
        case (state)
            ST_IDLE: begin
                if (iwb_stb_i && dwb_stb_i) state_nxt = (last == M_I) ? ST_DGNT : ST_IGNT;
                else if (dwb_stb_i)         state_nxt = ST_DGNT;
                else if (iwb_stb_i)         state_nxt = ST_IGNT;
            end
            ST_IGNT: begin
                if (slv_ack) begin
                    last_nxt = M_I;
                    if (dwb_stb_i)      state_nxt = ST_DGNT;
                    else if (iwb_stb_i) state_nxt = ST_IGNT;
                    else                state_nxt = ST_IDLE;
                end else if (tmo) begin
                    last_nxt  = M_I;
                    state_nxt = ST_IDLE;
                end else if (!iwb_stb_i) begin
                    state_nxt = ST_IDLE;          // fetch aborted
                end
            end
            ST_DGNT: begin
                if (slv_ack) begin
                    last_nxt = M_D;
                    // A DWB that keeps cyc high owns the bus across strobes
                    if (dwb_cyc_i)      state_nxt = ST_DGNT;
                    else if (iwb_stb_i) state_nxt = ST_IGNT;
                    else if (dwb_stb_i) state_nxt = ST_DGNT;
                    else                state_nxt = ST_IDLE;
                end else if (tmo) begin
                    last_nxt  = M_D;
                    state_nxt = ST_IDLE;
                end else if (!dwb_stb_i && !dwb_cyc_i) begin
                    state_nxt = ST_IDLE;          // lock released or aborted
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Slave-side mux and master acks/data, all decoded from the grant state
    always_comb begin
        xwb_adr_o = '0;
        xwb_dat_o = '0;
        xwb_sel_o = '0;
        xwb_wre_o = 1'b0;
        xwb_stb_o = 1'b0;
        xwb_cyc_o = 1'b0;
        iwb_ack_o = 1'b0;
        dwb_ack_o = 1'b0;
        iwb_dat_o = xwb_dat_i;
        dwb_dat_o = xwb_dat_i;
        case (state)
            ST_IGNT: begin
                xwb_adr_o = iwb_adr_i;
                xwb_sel_o = SEL_ALL;
                xwb_stb_o = iwb_stb_i & ~tmo;
                xwb_cyc_o = 1'b1;
                iwb_ack_o = slv_ack | tmo;
                if (tmo) iwb_dat_o = '0;
            end
            ST_DGNT: begin
                xwb_adr_o = dwb_adr_i;
                xwb_dat_o = dwb_dat_i;
                xwb_sel_o = dwb_sel_i;
                xwb_wre_o = dwb_wre_i;
                xwb_stb_o = dwb_stb_i & ~tmo;
                xwb_cyc_o = 1'b1;
                dwb_ack_o = slv_ack | tmo;
                if (tmo) dwb_dat_o = '0;
            end
            default: ;
        endcase
    end

    assign arb_tmo_o = tmo;

endmodule

// File: tb/tb_aemb_wb_arbiter.sv
// Directed self-checking bench for aemb_wb_arbiter (watchdog limit TMO=4).
module tb_aemb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:2] iwb_adr = '0;
    logic        iwb_stb = 1'b0;
    logic        iwb_ack;
    logic [31:0] iwb_dat;
    logic [15:2] dwb_adr = '0;
    logic [31:0] dwb_wdat = '0;
    logic [3:0]  dwb_sel = 4'hF;
    logic        dwb_wre = 1'b0;
    logic        dwb_stb = 1'b0;
    logic        dwb_cyc = 1'b0;
    logic        dwb_ack;
    logic [31:0] dwb_rdat;
    logic [15:2] xwb_adr;
    logic [31:0] xwb_wdat;
    logic [3:0]  xwb_sel;
    logic        xwb_wre, xwb_stb, xwb_cyc;
    logic        xwb_ack = 1'b0;
    logic [31:0] slv_dat = 32'hDEADBEEF;
    logic        arb_tmo;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    aemb_wb_arbiter #(.AW(16), .TMO(4), .TW(8)) dut (
        .sys_clk_i  (clk),
        .sys_rst_ni (rst_n),
        .iwb_adr_i  (iwb_adr),
        .iwb_stb_i  (iwb_stb),
        .iwb_ack_o  (iwb_ack),
        .iwb_dat_o  (iwb_dat),
        .dwb_adr_i  (dwb_adr),
        .dwb_dat_i  (dwb_wdat),
        .dwb_sel_i  (dwb_sel),
        .dwb_wre_i  (dwb_wre),
        .dwb_stb_i  (dwb_stb),
        .dwb_cyc_i  (dwb_cyc),
        .dwb_ack_o  (dwb_ack),
        .dwb_dat_o  (dwb_rdat),
        .xwb_adr_o  (xwb_adr),
        .xwb_dat_o  (xwb_wdat),
        .xwb_sel_o  (xwb_sel),
        .xwb_wre_o  (xwb_wre),
        .xwb_stb_o  (xwb_stb),
        .xwb_cyc_o  (xwb_cyc),
        .xwb_ack_i  (xwb_ack),
        .xwb_dat_i  (slv_dat),
        .arb_tmo_o  (arb_tmo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs changed afterwards settle
    // before the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    int n_i, n_d;

    initial begin
        // ---------------- reset state ----------------
        #3;
        check("rst_stb",  32'(xwb_stb), 32'h0);
        check("rst_cyc",  32'(xwb_cyc), 32'h0);
        check("rst_wre",  32'(xwb_wre), 32'h0);
        check("rst_iack", 32'(iwb_ack), 32'h0);
        check("rst_dack", 32'(dwb_ack), 32'h0);
        check("rst_tmo",  32'(arb_tmo), 32'h0);
        check("rst_adr",  32'(xwb_adr), 32'h0);
        check("rst_dat",  xwb_wdat,     32'h0);
        check("rst_sel",  32'(xwb_sel), 32'h0);
        #9 rst_n = 1'b1;
        tick();

        // ---------------- first tie: DWB wins, then IWB with no bubble ----
        iwb_adr = 14'h0010; iwb_stb = 1'b1;
        dwb_adr = 14'h0020; dwb_stb = 1'b1; dwb_cyc = 1'b0;
        settle();
        check("tie_latency_stb", 32'(xwb_stb), 32'h0);
        tick();
        settle();
        check("tie_dgnt_adr", 32'(xwb_adr), 32'h0020);
        check("tie_dgnt_stb", 32'(xwb_stb), 32'h1);
        xwb_ack = 1'b1;
        #1;
        check("tie_dack", 32'(dwb_ack), 32'h1);
        check("tie_iack_quiet", 32'(iwb_ack), 32'h0);
        check("dat_to_dwb", dwb_rdat, 32'hDEADBEEF);
        check("dat_to_iwb", iwb_dat,  32'hDEADBEEF);
        tick();
        dwb_stb = 1'b0; xwb_ack = 1'b0;
        settle();
        check("handover_adr", 32'(xwb_adr), 32'h0010);
        check("handover_stb", 32'(xwb_stb), 32'h1);
        check("handover_sel", 32'(xwb_sel), 32'hF);
        check("handover_wre", 32'(xwb_wre), 32'h0);
        xwb_ack = 1'b1;
        #1;
        check("iack", 32'(iwb_ack), 32'h1);
        check("dack_quiet", 32'(dwb_ack), 32'h0);
        tick();                               // back-to-back IGNT
        iwb_stb = 1'b0; xwb_ack = 1'b0;
        settle();
        check("abort_stb", 32'(xwb_stb), 32'h0);
        check("abort_noack", 32'(iwb_ack), 32'h0);
        tick();
        settle();
        check("idle_cyc", 32'(xwb_cyc), 32'h0);

        // ---------------- round robin over 100 transfers ----------------
        iwb_stb = 1'b1; dwb_stb = 1'b1; xwb_ack = 1'b1;
        n_i = 0; n_d = 0;
        tick();
        for (int i = 0; i < 100; i++) begin
            settle();
            check($sformatf("rr_%0d", i), 32'({iwb_ack, dwb_ack}),
                  (i % 2 == 0) ? 32'h1 : 32'h2);
            n_i += int'(iwb_ack);
            n_d += int'(dwb_ack);
            if (i < 99) tick();
        end
        check("rr_count_i", 32'(n_i), 32'd50);
        check("rr_count_d", 32'(n_d), 32'd50);
        dwb_stb = 1'b0;
        tick();                               // IWB back-to-back
        iwb_stb = 1'b0; xwb_ack = 1'b0;
        tick();                               // abort -> IDLE

        // ---------------- DWB byte write then locked cycle ----------------
        dwb_adr = 14'h0030; dwb_wdat = 32'h0000AB00; dwb_sel = 4'h2;
        dwb_wre = 1'b1; dwb_stb = 1'b1; dwb_cyc = 1'b1;
        tick();
        settle();
        check("bw_sel", 32'(xwb_sel), 32'h2);
        check("bw_wre", 32'(xwb_wre), 32'h1);
        check("bw_dat", xwb_wdat, 32'h0000AB00);
        check("bw_adr", 32'(xwb_adr), 32'h0030);
        iwb_stb = 1'b1; xwb_ack = 1'b1;
        #1;
        check("bw_dack", 32'(dwb_ack), 32'h1);
        check("bw_iack_quiet", 32'(iwb_ack), 32'h0);
        tick();
        dwb_stb = 1'b0; dwb_wre = 1'b0; dwb_sel = 4'hF; xwb_ack = 1'b0;
        for (int g = 0; g < 3; g++) begin
            settle();
            check($sformatf("lock_stb_%0d", g), 32'(xwb_stb), 32'h0);
            check($sformatf("lock_cyc_%0d", g), 32'(xwb_cyc), 32'h1);
            check($sformatf("lock_adr_%0d", g), 32'(xwb_adr), 32'h0030);
            tick();
        end
        dwb_adr = 14'h0031; dwb_stb = 1'b1; xwb_ack = 1'b1;
        settle();
        check("lock_rd_adr", 32'(xwb_adr), 32'h0031);
        check("lock_rd_dack", 32'(dwb_ack), 32'h1);
        tick();
        dwb_stb = 1'b0; dwb_cyc = 1'b0; xwb_ack = 1'b0;
        settle();
        check("lock_last_cyc", 32'(xwb_cyc), 32'h1);
        tick();
        settle();
        check("release_idle", 32'(xwb_cyc), 32'h0);
        tick();
        settle();
        check("iwb_after_lock_adr", 32'(xwb_adr), 32'h0010);
        check("iwb_after_lock_stb", 32'(xwb_stb), 32'h1);

        // ---------------- watchdog timeout on IWB (TMO=4) ----------------
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("wd_wait_ack_%0d", c), 32'(iwb_ack), 32'h0);
            check($sformatf("wd_wait_tmo_%0d", c), 32'(arb_tmo), 32'h0);
            tick();
            settle();
        end
        check("wd_iack", 32'(iwb_ack), 32'h1);
        check("wd_idat", iwb_dat, 32'h0);
        check("wd_ddat", dwb_rdat, 32'hDEADBEEF);
        check("wd_tmo", 32'(arb_tmo), 32'h1);
        check("wd_stb", 32'(xwb_stb), 32'h0);
        tick();
        iwb_stb = 1'b0;
        settle();
        check("wd_tmo_once", 32'(arb_tmo), 32'h0);
        check("wd_idle", 32'(xwb_cyc), 32'h0);

        // ---------------- slave ack on the timeout cycle wins ----------------
        iwb_stb = 1'b1;
        tick();
        settle();
        for (int c = 1; c <= 4; c++) begin
            tick();
            settle();
        end
        slv_dat = 32'h12345678; xwb_ack = 1'b1;
        #1;
        check("prec_iack", 32'(iwb_ack), 32'h1);
        check("prec_idat", iwb_dat, 32'h12345678);
        check("prec_no_tmo", 32'(arb_tmo), 32'h0);
        tick();
        iwb_stb = 1'b0; xwb_ack = 1'b0;
        tick();

        // ---------------- reset in the middle of a DWB transfer ----------------
        dwb_adr = 14'h0020; dwb_stb = 1'b1;
        tick();
        xwb_ack = 1'b1;
        settle();
        check("pre_rst_dack", 32'(dwb_ack), 32'h1);
        tick();                               // DWB served last, still in DGNT
        xwb_ack = 1'b0;
        settle();
        check("mid_dgnt_stb", 32'(xwb_stb), 32'h1);
        rst_n = 1'b0; dwb_stb = 1'b0; xwb_ack = 1'b1;
        #1;
        check("rst_async_stb", 32'(xwb_stb), 32'h0);
        check("rst_async_cyc", 32'(xwb_cyc), 32'h0);
        check("rst_dack_quiet", 32'(dwb_ack), 32'h0);
        #1 rst_n = 1'b1;
        #1;
        check("post_rst_dack", 32'(dwb_ack), 32'h0);
        tick();
        settle();
        check("post_rst_idle_dack", 32'(dwb_ack), 32'h0);
        check("post_rst_idle_cyc", 32'(xwb_cyc), 32'h0);
        xwb_ack = 1'b0;
        iwb_stb = 1'b1; dwb_stb = 1'b1;
        tick();
        settle();
        check("post_rst_tie_adr", 32'(xwb_adr), 32'h0020);
        check("post_rst_tie_stb", 32'(xwb_stb), 32'h1);
        iwb_stb = 1'b0; dwb_stb = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
